wb_aperture_decoder: RTL and testbench
======================================

Name: wb_aperture_decoder

Overview:
Parametrised Wishbone aperture decoder and interconnect for the AHB-to-FPGA bridge slave port. It routes one master cycle to one of NUM_SLAVES apertures and muxes read data and acks back to the master. A built-in timeout state machine completes any cycle that no slave acknowledges, returning DEFAULT_READ_VALUE, and records a sticky error with the offending address.

Parameters:
NUM_SLAVES, 4, number of slave apertures (1..8)
APERWIDTH, 17, master byte-address width
APERSIZE, 10, word-address bits per aperture; decode compares ADR[APERWIDTH-1:APERSIZE+2]
BASE_ADDRS, {17'h12000,17'h02000,17'h01000,17'h00000}, packed NUM_SLAVES*APERWIDTH byte bases, slave 0 in LSBs
TIMEOUT_CNTR_WIDTH, 3, timeout counter width
TIMEOUT_CYCLES, 7, wait cycles before forced ack (1..2^TIMEOUT_CNTR_WIDTH-1)
DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, data returned on timeout

Ports:
WBs_CLK_i  in  1  Wishbone clock
WBs_RST_n_i  in  1  asynchronous active-low reset
WBs_ADR_i  in  APERWIDTH  master byte address
WBs_CYC_i  in  1  master cycle
WBs_STB_i  in  1  master strobe
WBs_WE_i  in  1  write enable
WBs_BYTE_STB_i  in  4  byte enables (passed through unchanged by the integrator)
WBs_DAT_o  out  32  read data to master
WBs_ACK_o  out  1  ack to master
WBs_CYC_o  out  NUM_SLAVES  per-slave cycle select
WBs_DAT_i  in  32*NUM_SLAVES  packed slave read data, slave 0 in LSBs
WBs_ACK_i  in  NUM_SLAVES  per-slave acks
Err_Clr_i  in  1  clears error status
Bus_Err_o  out  1  sticky timeout flag
Err_ADR_o  out  APERWIDTH  address of the first timed-out cycle since the last clear
Err_Cnt_o  out  8  saturating timeout count

Behaviour:
- Reset state: FSM IDLE, counter 0, Bus_Err_o=0, Err_ADR_o=0, Err_Cnt_o=0. WBs_ACK_o=0 while reset is asserted.
- Decode (combinational): hit[k] = ADR upper bits equal to BASE_ADDRS[k] upper bits. Overlapping apertures resolve to the lowest index. sel is one-hot or zero.
- WBs_CYC_o[k] = WBs_CYC_i & sel[k] & (state != ACK).
- Slave ack: slv_ack = |(WBs_ACK_i & sel). Acks from unselected slaves are ignored.
- WBs_ACK_o = slv_ack | (state==ACK). WBs_DAT_o = selected slave's data when slv_ack; DEFAULT_READ_VALUE when state==ACK or no slave is selected; otherwise undefined-but-stable (driven with DEFAULT_READ_VALUE).
- FSM states: IDLE, COUNT, ACK.
  - IDLE -> COUNT when CYC&STB & ~slv_ack; counter is cleared.
  - COUNT: counter increments each cycle.
    - -> IDLE on slv_ack, or when CYC or STB drops (abort, no error).
    - -> ACK when counter == TIMEOUT_CYCLES-1 and ~slv_ack.
  - ACK: lasts exactly one cycle. Drives the ack and discards writes. Sets Bus_Err_o. Err_ADR_o is captured only if Bus_Err_o was 0. Err_Cnt_o increments and saturates at 255. Then -> IDLE unconditionally.
- A zero-wait slave ack in the same cycle as CYC&STB completes the access with FSM staying in IDLE.
- Simultaneous slave ack and timeout expiry: slave ack wins, no error is logged.
- Timeout latency: forced ack is asserted TIMEOUT_CYCLES+1 cycles after STB rises (default 8).
- Err_Clr_i clears all error status. Err_Clr_i in the same cycle as an ACK-state event: clear wins, then the new event is applied (status = Bus_Err 1, new address, count 1).
- Reset mid-cycle: FSM returns to IDLE immediately. Any pending access gets no ack; the master relies on bridge-level reset.

Optional Feature:
WB_FAST_UNMAPPED_ACK_EN
- Defined: when CYC&STB hits no aperture, IDLE goes directly to ACK, giving a one-cycle-latency default ack. This is logged as an error like a timeout.
- Undefined: unmapped accesses take the full timeout path.

Decomposition:
- Package wb_aperture_pkg: FSM state encoding (IDLE=2'd0, COUNT=2'd1, ACK=2'd2), ERR_CNT_WIDTH=8, DEFAULT_READ_VALUE constant, aperture-match function.
- Sub-module wb_timeout_fsm: FSM, counter and error registers.
- Top: decode and muxing.

Test Plan:
- Read of 0x01004, slave 1 acks after 2 cycles with 0x0000_00A5 -> WBs_ACK_o high in that cycle, WBs_DAT_o=0x0000_00A5, WBs_CYC_o=4'b0010, Bus_Err_o=0.
- Read of 0x02000, slave 2 never acks -> ack 8 cycles after STB, WBs_DAT_o=0xBAD_FAB_AC, Bus_Err_o=1, Err_ADR_o=0x02000, Err_Cnt_o=1.
- Slave ack on the exact expiry cycle -> slave data returned, single ack pulse, Err_Cnt_o unchanged.
- Two timeouts (0x02000 then 0x12004), then Err_Clr_i pulse -> Err_ADR_o holds 0x02000 and Err_Cnt_o=2 before the clear; all zero after.
- Unmapped 0x08000 -> without the macro, ack after 8 cycles; with WB_FAST_UNMAPPED_ACK_EN, ack on the next cycle; both return 0xBAD_FAB_AC and set the error.
- Assert WBs_RST_n_i low during COUNT -> no ack, FSM IDLE, all status 0; a subsequent access completes normally.

Source files
------------

// File: rtl/wb_aperture_pkg.sv
// ---------------------------------------------------------------------------
// wb_aperture_pkg
// Shared definitions for the Wishbone aperture decoder:
//   - timeout FSM state encoding
//   - error counter width
//   - default read value returned on forced (timeout/unmapped) acks
//   - aperture_match(): compares the upper address bits of an address against
//     an aperture base, ignoring the bits at or below bit position lsb-1
// ---------------------------------------------------------------------------
package wb_aperture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_ACK   = 2'd2
   } wb_to_state_e;

   localparam int          ERR_CNT_WIDTH          = 8;
   localparam logic [31:0] DEFAULT_READ_VALUE_DEF = 32'hBAD_FAB_AC;

   // Addresses are passed zero-extended to 32 bits so one function serves
   // every APERWIDTH up to 32.
   function automatic logic aperture_match(input logic [31:0] adr,
                                           input logic [31:0] base,
                                           input int          lsb);
      logic [31:0] diff;
      diff = (adr ^ base) >> lsb;
      return (diff == 32'd0);
   endfunction

endpackage

// File: rtl/wb_aperture_decoder_fsm.sv
// ---------------------------------------------------------------------------
// wb_timeout_fsm
// Timeout state machine, wait counter and sticky error status for the
// aperture decoder. Completes any master cycle that no slave acknowledges
// within TIMEOUT_CYCLES wait cycles by spending one cycle in ST_ACK.
//
// Configuration macro: WB_FAST_UNMAPPED_ACK_EN
//   defined   - a request that hits no aperture goes straight to ST_ACK
//   undefined - unmapped requests take the full timeout path
//
// Ports:
//   WBs_CLK_i    clock
//   WBs_RST_n_i  asynchronous active-low reset
//   req_i        master CYC & STB
//   slv_ack_i    ack from the selected slave
//   unmapped_i   request address hits no aperture
//   adr_i        master address (captured on the first error)
//   err_clr_i    clear all error status
//   ack_state_o  FSM is in ST_ACK (forced ack cycle)
//   bus_err_o    sticky error flag
//   err_adr_o    address of the first error since the last clear
//   err_cnt_o    saturating error count
// ---------------------------------------------------------------------------
module wb_timeout_fsm
   import wb_aperture_pkg::*;
#(
   parameter int APERWIDTH          = 17,
   parameter int TIMEOUT_CNTR_WIDTH = 3,
   parameter int TIMEOUT_CYCLES     = 7
) (
   input  logic                     WBs_CLK_i,
   input  logic                     WBs_RST_n_i,
   input  logic                     req_i,
   input  logic                     slv_ack_i,
   input  logic                     unmapped_i,
   input  logic [APERWIDTH-1:0]     adr_i,
   input  logic                     err_clr_i,
   output logic                     ack_state_o,
   output logic                     bus_err_o,
   output logic [APERWIDTH-1:0]     err_adr_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

   localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LAST = TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

   wb_to_state_e                  state_q, state_d;
   logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q, cnt_d;
   logic                          bus_err_q, bus_err_d;
   logic [APERWIDTH-1:0]          err_adr_q, err_adr_d;
   logic [ERR_CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

`ifndef WB_FAST_UNMAPPED_ACK_EN
   logic unused_unmapped;
   assign unused_unmapped = unmapped_i;
`endif

   always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
      if (!WBs_RST_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
         err_adr_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         err_adr_q <= err_adr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // A zero-wait slave ack completes the access without leaving IDLE.
            if (req_i && !slv_ack_i) begin
               cnt_d = '0;
`ifdef WB_FAST_UNMAPPED_ACK_EN
               state_d = unmapped_i ? ST_ACK : ST_COUNT;
`else
               state_d = ST_COUNT;
`endif
            end
         end
         ST_COUNT: begin
            cnt_d = cnt_q + 1'b1;
            // Slave ack takes priority over expiry; a dropped request aborts
            // silently.
            if (slv_ack_i || !req_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Clear is applied first so that a forced ack in the same cycle starts a
   // fresh error record.
   always_comb begin
      bus_err_d = bus_err_q;
      err_adr_d = err_adr_q;
      err_cnt_d = err_cnt_q;
      if (err_clr_i) begin
         bus_err_d = 1'b0;
         err_adr_d = '0;
         err_cnt_d = '0;
      end
      if (state_q == ST_ACK) begin
         if (!bus_err_d) begin
            err_adr_d = adr_i;
         end
         bus_err_d = 1'b1;
         if (err_cnt_d != '1) begin
            err_cnt_d = err_cnt_d + 1'b1;
         end
      end
   end

   assign ack_state_o = (state_q == ST_ACK);
   assign bus_err_o   = bus_err_q;
   assign err_adr_o   = err_adr_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/wb_aperture_decoder.sv
// ---------------------------------------------------------------------------
// wb_aperture_decoder
// Wishbone aperture decoder / interconnect. Routes a master cycle to one of
// NUM_SLAVES apertures, muxes read data and acks back, and forces an ack with
// DEFAULT_READ_VALUE (plus a sticky error) when no slave responds.
//
// Configuration macro: WB_FAST_UNMAPPED_ACK_EN (see wb_timeout_fsm) gives a
// one-cycle default ack for accesses that hit no aperture.
//
// Ports:
//   WBs_CLK_i / WBs_RST_n_i     clock, asynchronous active-low reset
//   WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i  master request
//   WBs_DAT_o, WBs_ACK_o        read data and ack to the master
//   WBs_CYC_o                   per-slave cycle select
//   WBs_DAT_i, WBs_ACK_i        packed slave read data (slave 0 in LSBs), acks
//   Err_Clr_i                   clear error status
//   Bus_Err_o, Err_ADR_o, Err_Cnt_o  sticky error flag, first address, count
// ---------------------------------------------------------------------------
module wb_aperture_decoder
   import wb_aperture_pkg::*;
#(
   parameter int                              NUM_SLAVES         = 4,
   parameter int                              APERWIDTH          = 17,
   parameter int                              APERSIZE           = 10,
   parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS         = {17'h12000, 17'h02000, 17'h01000, 17'h00000},
   parameter int                              TIMEOUT_CNTR_WIDTH = 3,
   parameter int                              TIMEOUT_CYCLES     = 7,
   parameter logic [31:0]                     DEFAULT_READ_VALUE = DEFAULT_READ_VALUE_DEF
) (
   input  logic                     WBs_CLK_i,
   input  logic                     WBs_RST_n_i,
   input  logic [APERWIDTH-1:0]     WBs_ADR_i,
   input  logic                     WBs_CYC_i,
   input  logic                     WBs_STB_i,
   input  logic                     WBs_WE_i,
   input  logic [3:0]               WBs_BYTE_STB_i,
   output logic [31:0]              WBs_DAT_o,
   output logic                     WBs_ACK_o,
   output logic [NUM_SLAVES-1:0]    WBs_CYC_o,
   input  logic [32*NUM_SLAVES-1:0] WBs_DAT_i,
   input  logic [NUM_SLAVES-1:0]    WBs_ACK_i,
   input  logic                     Err_Clr_i,
   output logic                     Bus_Err_o,
   output logic [APERWIDTH-1:0]     Err_ADR_o,
   output logic [ERR_CNT_WIDTH-1:0] Err_Cnt_o
);

   logic [NUM_SLAVES-1:0] hit;
   logic [NUM_SLAVES-1:0] sel;
   logic                  slv_ack;
   logic                  ack_state;
   logic [31:0]           slv_dat;

   // Write enable and byte strobes go straight from master to slaves outside
   // this block; they play no part in decoding.
   logic unused_inputs;
   assign unused_inputs = ^{WBs_WE_i, WBs_BYTE_STB_i};

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
      assign hit[gi] = aperture_match(32'(WBs_ADR_i),
                                      32'(BASE_ADDRS[gi*APERWIDTH +: APERWIDTH]),
                                      APERSIZE + 2);
   end

   // Isolate the lowest set bit: overlapping apertures go to the lowest index.
   assign sel = hit & (~hit + NUM_SLAVES'(1));

   assign slv_ack = |(WBs_ACK_i & sel);

   always_comb begin
      slv_dat = DEFAULT_READ_VALUE;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel[k]) begin
            slv_dat = WBs_DAT_i[32*k +: 32];
         end
      end
   end

   // Slaves are deselected in the forced-ack cycle, so writes are dropped.
   assign WBs_CYC_o = sel & {NUM_SLAVES{WBs_CYC_i & ~ack_state}};
   assign WBs_ACK_o = WBs_RST_n_i & (slv_ack | ack_state);
   assign WBs_DAT_o = (slv_ack && !ack_state) ? slv_dat : DEFAULT_READ_VALUE;

   wb_timeout_fsm #(
      .APERWIDTH          (APERWIDTH),
      .TIMEOUT_CNTR_WIDTH (TIMEOUT_CNTR_WIDTH),
      .TIMEOUT_CYCLES     (TIMEOUT_CYCLES)
   ) u_timeout_fsm (
      .WBs_CLK_i   (WBs_CLK_i),
      .WBs_RST_n_i (WBs_RST_n_i),
      .req_i       (WBs_CYC_i & WBs_STB_i),
      .slv_ack_i   (slv_ack),
      .unmapped_i  (~|hit),
      .adr_i       (WBs_ADR_i),
      .err_clr_i   (Err_Clr_i),
      .ack_state_o (ack_state),
      .bus_err_o   (Bus_Err_o),
      .err_adr_o   (Err_ADR_o),
      .err_cnt_o   (Err_Cnt_o)
   );

endmodule

// File: tb/tb_wb_aperture_decoder.sv
// ---------------------------------------------------------------------------
// tb_wb_aperture_decoder
// Self-checking bench for wb_aperture_decoder: a directed vector table, hand
// sequences for clear/reset/saturation corners, then randomized accesses
// checked against a cycle-count reference model of the decoder.
// ---------------------------------------------------------------------------
module tb_wb_aperture_decoder;

`ifdef WB_FAST_UNMAPPED_ACK_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int          UNMAP_ACK = FAST ? 1 : 8;
   localparam logic [31:0] DEF       = 32'hBAD_FAB_AC;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [16:0]  adr;
   logic         cyc, stb, we;
   logic [3:0]   bstb;
   logic [31:0]  dat_o;
   logic         ack_o;
   logic [3:0]   cyc_o;
   logic [127:0] dat_bus;
   logic [3:0]   ack_i;
   logic         clr;
   logic         bus_err;
   logic [16:0]  err_adr;
   logic [7:0]   err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model error status
   logic        m_err;
   logic [16:0] m_adr;
   int          m_cnt;

   logic [16:0] tb_base [4] = '{17'h00000, 17'h01000, 17'h02000, 17'h12000};

   always #5 clk = ~clk;

   wb_aperture_decoder dut (
      .WBs_CLK_i      (clk),
      .WBs_RST_n_i    (rst_n),
      .WBs_ADR_i      (adr),
      .WBs_CYC_i      (cyc),
      .WBs_STB_i      (stb),
      .WBs_WE_i       (we),
      .WBs_BYTE_STB_i (bstb),
      .WBs_DAT_o      (dat_o),
      .WBs_ACK_o      (ack_o),
      .WBs_CYC_o      (cyc_o),
      .WBs_DAT_i      (dat_bus),
      .WBs_ACK_i      (ack_i),
      .Err_Clr_i      (clr),
      .Bus_Err_o      (bus_err),
      .Err_ADR_o      (err_adr),
      .Err_Cnt_o      (err_cnt)
   );

   typedef struct {
      logic [16:0] adr;
      logic [3:0]  mask;
      int          c;
      int          exp_ack;
      logic [3:0]  exp_cyc;
      logic [31:0] exp_dat;
      logic        exp_err;
      logic [16:0] exp_eadr;
      int          exp_cnt;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One master access held until the expected ack cycle. Slave acks from
   // 'mask' are driven in cycle c (cycle 0 = first STB cycle).
   task automatic run_access(input logic [16:0] a, input logic [3:0] mask, input int c,
                             input bit clr_at_ack, input int exp_ack, input logic [3:0] exp_cyc,
                             input logic [31:0] exp_dat, input string tag);
      $display("txn %s adr=%05h mask=%b slave_ack_cycle=%0d expect_ack_cycle=%0d", tag, a, mask, c, exp_ack);
      for (int i = 0; i <= exp_ack; i++) begin
         @(posedge clk); #1;
         adr   = a;
         cyc   = 1'b1;
         stb   = 1'b1;
         ack_i = (i == c) ? mask : 4'b0000;
         clr   = clr_at_ack && (i == exp_ack);
         @(negedge clk);
         if (i < exp_ack) begin
            chk({tag, "_noack"}, ack_o, 0);
            chk({tag, "_cyc_o"}, cyc_o, exp_cyc);
         end else begin
            chk({tag, "_ack"}, ack_o, 1);
            chk({tag, "_dat"}, dat_o, exp_dat);
         end
      end
      @(posedge clk); #1;
      cyc   = 1'b0;
      stb   = 1'b0;
      ack_i = 4'b0000;
      clr   = 1'b0;
   endtask

   task automatic check_status(input logic e, input logic [16:0] ea, input int ec, input string tag);
      @(negedge clk);
      chk({tag, "_bus_err"}, bus_err, e);
      chk({tag, "_err_adr"}, err_adr, ea);
      chk({tag, "_err_cnt"}, err_cnt, ec);
   endtask

   function automatic logic [3:0] model_sel(input logic [16:0] a);
      for (int k = 0; k < 4; k++) begin
         if ((a >> 12) == (tb_base[k] >> 12)) return 4'(1 << k);
      end
      return 4'b0000;
   endfunction

   initial begin
      logic [16:0] a;
      logic [3:0]  mask, s;
      logic [31:0] ed;
      int          c, t, ea, k;
      bit          valid, rclr;

      vecs[0] = '{17'h01004, 4'b0010,  2, 2,         4'b0010, 32'h0000_00A5, 1'b0, 17'h00000, 0};
      vecs[1] = '{17'h02000, 4'b0000, -1, 8,         4'b0100, DEF,           1'b1, 17'h02000, 1};
      vecs[2] = '{17'h00010, 4'b0001,  7, 7,         4'b0001, 32'h1111_0000, 1'b1, 17'h02000, 1};
      vecs[3] = '{17'h12004, 4'b0000, -1, 8,         4'b1000, DEF,           1'b1, 17'h02000, 2};
      vecs[4] = '{17'h08000, 4'b0000, -1, UNMAP_ACK, 4'b0000, DEF,           1'b1, 17'h02000, 3};
      vecs[5] = '{17'h01008, 4'b0010,  0, 0,         4'b0010, 32'h0000_00A5, 1'b1, 17'h02000, 3};
      vecs[6] = '{17'h00020, 4'b0010,  1, 8,         4'b0001, DEF,           1'b1, 17'h02000, 4};

      rst_n = 1'b0; adr = '0; cyc = 0; stb = 0; we = 0; bstb = 4'hF;
      ack_i = '0; clr = 0;
      dat_bus = {32'h3333_3333, 32'h2222_2222, 32'h0000_00A5, 32'h1111_0000};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ack", ack_o, 0);
      chk("reset_bus_err", bus_err, 0);
      chk("reset_err_adr", err_adr, 0);
      chk("reset_err_cnt", err_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vector table
      for (int v = 0; v < 7; v++) begin
         run_access(vecs[v].adr, vecs[v].mask, vecs[v].c, 1'b0, vecs[v].exp_ack,
                    vecs[v].exp_cyc, vecs[v].exp_dat, $sformatf("vec%0d", v));
         check_status(vecs[v].exp_err, vecs[v].exp_eadr, vecs[v].exp_cnt, $sformatf("vec%0d", v));
      end

      // Clear pulse
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      $display("txn err_clr");
      check_status(0, 17'h0, 0, "clr");

      // Clear coinciding with a forced ack: the new event starts a fresh record
      run_access(17'h12004, 4'b0000, -1, 1'b0, 8, 4'b1000, DEF, "pre_clr_ack");
      check_status(1, 17'h12004, 1, "pre_clr_ack");
      run_access(17'h02000, 4'b0000, -1, 1'b1, 8, 4'b0100, DEF, "clr_at_ack");
      check_status(1, 17'h02000, 1, "clr_at_ack");

      // Reset in the middle of a waiting access
      $display("txn reset_mid_count adr=02000");
      @(posedge clk); #1;
      adr = 17'h02000; cyc = 1; stb = 1; ack_i = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_pre_noack", ack_o, 0);
         @(posedge clk); #1;
      end
      rst_n = 1'b0; adr = 17'h01004; ack_i = 4'b0010;
      @(negedge clk);
      chk("rst_mid_ack", ack_o, 0);
      chk("rst_mid_bus_err", bus_err, 0);
      chk("rst_mid_err_adr", err_adr, 0);
      chk("rst_mid_err_cnt", err_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; cyc = 0; stb = 0; ack_i = 4'b0000;
      @(negedge clk);
      chk("rst_release_ack", ack_o, 0);
      run_access(17'h01004, 4'b0010, 1, 1'b0, 1, 4'b0010, 32'h0000_00A5, "post_rst");
      check_status(0, 17'h0, 0, "post_rst");

      // Error count saturation
      for (int n = 0; n < 256; n++) begin
         run_access((n == 0) ? 17'h12004 : 17'h02000, 4'b0000, -1, 1'b0, 8,
                    (n == 0) ? 4'b1000 : 4'b0100, DEF, "sat");
         if (n == 254) check_status(1, 17'h12004, 255, "sat_reach");
      end
      check_status(1, 17'h12004, 255, "sat_hold");
      m_err = 1'b1; m_adr = 17'h12004; m_cnt = 255;

      // Clear before the random run so the model sees unsaturated counts too
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      $display("txn err_clr");
      check_status(0, 17'h0, 0, "clr2");
      m_err = 1'b0; m_adr = '0; m_cnt = 0;

      // Randomized accesses against the reference model
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 4);
         if (k == 4) a = 17'($urandom);
         else        a = tb_base[k] | 17'($urandom_range(0, 4095));
         mask = 4'($urandom);
         c = $urandom_range(0, 9);
         if (c > 7) c = -1;
         rclr = ($urandom_range(0, 7) == 0);
         dat_bus = {$urandom, $urandom, $urandom, $urandom};

         s     = model_sel(a);
         t     = (FAST && s == 4'b0000) ? 1 : 8;
         valid = ((s & mask) != 4'b0000) && (c >= 0) && (c < t);
         ea    = valid ? c : t;
         ed    = DEF;
         if (valid) begin
            for (int j = 0; j < 4; j++) if (s[j]) ed = dat_bus[32*j +: 32];
         end

         run_access(a, mask, c, rclr, ea, s, ed, "rnd");

         if (rclr) begin
            m_err = 1'b0; m_adr = '0; m_cnt = 0;
         end
         if (!valid) begin
            if (!m_err) m_adr = a;
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
         check_status(m_err, m_adr, m_cnt, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
